rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Sequencing arbiter that shares one downstream resource among N requesters.
- Winner is selected by rotating (round-robin) priority, or by fixed highest-index priority, matching the team's priority-encoder ordering where bit 7 is highest.
- Grant is registered and held until the owner releases its request.
- Outputs both one-hot and encoded grant, so it can feed the encoder-indexed datapath directly.

Parameters:
- N, 8, number of requesters (2..16).
- IDW, $clog2(N) (3 for N=8), width of the encoded grant index.
- MAX_HOLD, 16, max grant duration in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  arbitration enable; when low, no new grant is issued.
- fixed_pri  in  1  1 = fixed priority (highest index wins); 0 = round-robin.
- req  in  N  request vector; requester k holds req[k] high for as long as it needs the resource.
- gnt  out  N  registered one-hot grant; at most one bit set.
- gnt_id  out  IDW  encoded index of the current owner; 0 when gnt_valid=0.
- gnt_valid  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse on forced revoke; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at an edge): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, state=IDLE, hold counter=0. Applies mid-grant as well; the grant drops on that same edge.
- State IDLE:
  - If en=1 and |req: at the next edge go to GRANT, register winner w: gnt=1<<w, gnt_id=w, gnt_valid=1.
  - Latency is 1 cycle from the sampled req to gnt.
  - Otherwise stay in IDLE.
- Winner selection, combinational on sampled req:
  - fixed_pri=1: highest set index.
  - fixed_pri=0: first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- State GRANT, owner o:
  - req[o]=1: hold gnt, gnt_id and gnt_valid unchanged regardless of other requests, en or fixed_pri.
  - req[o]=0 sampled: ptr<=(o+1) mod N on that edge.
  - Same edge, if en=1 and another request is pending: grant the new winner directly, computed with the updated ptr (back-to-back, no idle cycle, stay in GRANT).
  - Otherwise: clear gnt, gnt_id=0, gnt_valid=0, go to IDLE.
- ptr updates on every release in both modes.
- fixed_pri change takes effect at the next arbitration decision only.
- Simultaneous requests resolve in a single decision; there are no ties.
- Requests arriving during a grant wait; they are never lost as long as they stay asserted.
- en dropping mid-grant does not revoke the grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - Hold counter clears on each new grant and increments each GRANT cycle.
  - When the owner's grant has been held MAX_HOLD cycles with req[o] still high, the next edge forces a revoke: timeout=1 for one cycle, ptr<=(o+1) mod N.
  - The same edge re-arbitrates with o excluded; if no other requester is present, o is re-granted and the counter clears.
  - en=0 at the revoke edge: gnt clears and the state goes to IDLE.
- Disabled: no counter, grants are held indefinitely, timeout tied 0.

Test Plan:
- Reset mid-grant: owner 3 holding, assert rst one cycle -> next edge gnt=0, gnt_valid=0, gnt_id=0, ptr=0. After release, req=8'h01 -> gnt=8'h01 one cycle later.
- Round-robin rotation: fixed_pri=0, req=8'hFF constant, each owner drops req for one cycle then re-raises -> owners 0,1,2,...,7,0 in order. Grants are back-to-back with no gnt_valid gap.
- Fixed priority: fixed_pri=1, req=8'h25 -> gnt=8'h20, gnt_id=5. Release bit 5 -> gnt=8'h04, gnt_id=2.
- Hold and enable gating:
  - Owner 2 holding; req[6] rises, then en=0 -> gnt stays 8'h04.
  - Release bit 2 while en=0 -> gnt=0, IDLE.
  - en=1 -> gnt=8'h40 next cycle.
- Wrap-around: ptr=7 after owner 6 released, req=8'h81 -> gnt=8'h80. Release -> gnt=8'h01.
- ARB_TIMEOUT_EN, MAX_HOLD=16, req=8'h03 held constant: owner 0 granted; after 16 grant cycles timeout pulses for exactly 1 cycle and gnt=8'h02. With req=8'h01 only, owner 0 is re-granted and timeout pulses.

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters (master) and the arbiter (slave)
interface rr_arbiter8_if #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
);
  logic           en;
  logic           fixed_pri;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;
  modport master (output en, fixed_pri, req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input en, fixed_pri, req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin / fixed-priority arbiter with held registered grant; define ARB_TIMEOUT_EN for forced revoke after MAX_HOLD cycles
module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_cfg
    $error("rr_arbiter8: unsupported N or MAX_HOLD");
  end
  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d, cand;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, nxt, arb_ptr, win;
  logic           expire;
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p, input logic fp);
    logic [IDW-1:0] w, k;
    w = '0;
    for (int i = 0; i < N; i++) if (fp && r[i]) w = IDW'(i);
    for (int i = N - 1; i >= 0; i--) begin
      k = IDW'((int'(p) + i) % N);
      if (!fp && r[k]) w = k;
    end
    return w;
  endfunction
  // During a grant the next decision excludes the owner and scans from just past it
  assign nxt     = (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
  assign cand    = (state_q == GRANT) ? bus.req & ~gnt_q : bus.req;
  assign arb_ptr = (state_q == GRANT) ? nxt : ptr_q;
  assign win     = pick(cand, arb_ptr, bus.fixed_pri);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  assign expire = state_q == GRANT && bus.req[id_q] && cnt_q == CW'(MAX_HOLD - 1);
  // Hold counter runs while the owner keeps its grant, clears on any new decision
  always_comb begin
    cnt_d     = (state_q == GRANT && bus.req[id_q] && !expire) ? cnt_q + 1'b1 : '0;
    timeout_d = expire;
  end
  // Hold counter and revoke pulse registers
  always_ff @(posedge clk) begin
    cnt_q     <= rst ? '0 : cnt_d;
    timeout_q <= rst ? 1'b0 : timeout_d;
  end
  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  // Next grant: issue from IDLE, hold while owned, hand over or go idle on release/revoke
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (bus.en && |bus.req) begin
        state_d = GRANT;
        gnt_d   = N'(1) << win;
        id_d    = win;
      end
    end else if (!bus.req[id_q] || expire) begin
      ptr_d = nxt;
      if (bus.en && |cand) begin
        gnt_d = N'(1) << win;
        id_d  = win;
      end else if (!(bus.en && expire)) begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    end
  end
  // Grant, owner index and rotation pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = state_q == GRANT;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors for rr_arbiter8 (timeout section runs only with ARB_TIMEOUT_EN)
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  rr_arbiter8_if #(.N(8)) bus ();
  rr_arbiter8 #(.N(8), .MAX_HOLD(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] id, input logic v);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
  endtask
  initial begin
    logic [7:0] exp_g;
    bus.en = 1'b0;
    bus.fixed_pri = 1'b0;
    bus.req = '0;
    tick();
    chk_gnt("reset", 8'h00, 3'd0, 1'b0);
    chk("reset.timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
    bus.en = 1'b1;
    bus.req = 8'h08;
    tick();
    chk_gnt("grant3", 8'h08, 3'd3, 1'b1);
    bus.req = 8'h00;
    tick();
    chk_gnt("release3", 8'h00, 3'd0, 1'b0);
    bus.req = 8'h10;
    tick();
    chk_gnt("grant4", 8'h10, 3'd4, 1'b1);
    rst = 1'b1;
    tick();
    chk_gnt("rst_mid", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    bus.req = 8'h00;
    tick();
    bus.req = 8'h11;
    tick();
    chk_gnt("ptr_reset", 8'h01, 3'd0, 1'b1);
    bus.req = 8'hFF;
    tick();
    chk_gnt("rr_hold0", 8'h01, 3'd0, 1'b1);
    for (int o = 0; o < 8; o++) begin
      exp_g = 8'h01 << ((o + 1) % 8);
      bus.req = 8'hFF & ~(8'h01 << o);
      tick();
      chk_gnt($sformatf("rr_next%0d", (o + 1) % 8), exp_g, 3'((o + 1) % 8), 1'b1);
      bus.req = 8'hFF;
      tick();
      chk($sformatf("rr_hold%0d", (o + 1) % 8), 32'(bus.gnt), 32'(exp_g));
    end
    bus.fixed_pri = 1'b1;
    bus.req = 8'h00;
    tick();
    chk_gnt("fp_idle", 8'h00, 3'd0, 1'b0);
    bus.req = 8'h25;
    tick();
    chk_gnt("fp_25", 8'h20, 3'd5, 1'b1);
    bus.req = 8'h05;
    tick();
    chk_gnt("fp_05", 8'h04, 3'd2, 1'b1);
    bus.fixed_pri = 1'b0;
    bus.req = 8'h44;
    tick();
    chk_gnt("hold_44", 8'h04, 3'd2, 1'b1);
    bus.en = 1'b0;
    tick();
    chk_gnt("hold_en0", 8'h04, 3'd2, 1'b1);
    bus.req = 8'h40;
    tick();
    chk_gnt("rel_en0", 8'h00, 3'd0, 1'b0);
    bus.en = 1'b1;
    tick();
    chk_gnt("en1_40", 8'h40, 3'd6, 1'b1);
    bus.req = 8'h81;
    tick();
    chk_gnt("wrap_80", 8'h80, 3'd7, 1'b1);
    bus.req = 8'h01;
    tick();
    chk_gnt("wrap_01", 8'h01, 3'd0, 1'b1);
    chk("no_timeout", 32'(bus.timeout), 32'd0);
`ifdef ARB_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 8'h03;
    tick();
    chk_gnt("to_grant0", 8'h01, 3'd0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), 32'({bus.timeout, bus.gnt}), 32'h001);
    end
    tick();
    chk("to_revoke", 32'({bus.timeout, bus.gnt}), 32'h102);
    tick();
    chk("to_after", 32'({bus.timeout, bus.gnt}), 32'h002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 8'h01;
    tick();
    chk_gnt("to_solo", 8'h01, 3'd0, 1'b1);
    for (int i = 1; i < 16; i++) tick();
    chk("to_solo_pre", 32'({bus.timeout, bus.gnt}), 32'h001);
    tick();
    chk("to_regrant", 32'({bus.timeout, bus.gnt}), 32'h101);
    tick();
    chk("to_regrant_after", 32'({bus.timeout, bus.gnt}), 32'h001);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
